// File: rtl/asteroids_pkg.sv
// rtl/asteroids_pkg.sv - shared asteroid types, point values and counter sizing
package asteroids_pkg;

    typedef enum logic [1:0] {
        AST_LARGE = 2'd0,
        AST_MED   = 2'd1,
        AST_SMALL = 2'd2,
        AST_NONE  = 2'd3
    } ast_size_t;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        SPAWN = 2'd1,
        ALIVE = 2'd2
    } ctrl_state_t;

    localparam int PTS_LARGE_DEF = 20;
    localparam int PTS_MED_DEF   = 50;
    localparam int PTS_SMALL_DEF = 100;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/asteroid_hit_ctrl_if.sv
// rtl/asteroid_hit_ctrl_if.sv - pixel-mask inputs and game-control outputs of the hit controller
interface asteroid_hit_ctrl_if
    import asteroids_pkg::*;
#(
    parameter int SCORE_W = 16
);
    logic               vsync;
    logic               pixel_valid;
    logic               asteroid_px;
    logic               torpedo_px;
    logic               ship_px;
    logic               new_asteroid;
    logic               asteroid_hit;
    logic               torpedo_kill;
    logic               ship_hit;
    ast_size_t          size_level;
    logic [SCORE_W-1:0] score;

    modport master (
        output vsync, pixel_valid, asteroid_px, torpedo_px, ship_px,
        input  new_asteroid, asteroid_hit, torpedo_kill, ship_hit, size_level, score
    );

    modport slave (
        input  vsync, pixel_valid, asteroid_px, torpedo_px, ship_px,
        output new_asteroid, asteroid_hit, torpedo_kill, ship_hit, size_level, score
    );
endinterface

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - loadable down-counter stepped once per frame, reports zero and <=1
module frame_counter
    import asteroids_pkg::*;
#(
    parameter int MAX_VAL  = 1,
    parameter bit RST_FULL = 1'b0
) (
    input  logic clk,
    input  logic resetN,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o,
    output logic le_one_o
);
    localparam int W = cnt_w(MAX_VAL);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_q <= RST_FULL ? W'(MAX_VAL) : '0;
        end else if (load_i) begin
            cnt_q <= W'(MAX_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o   = (cnt_q == '0);
    assign le_one_o = (cnt_q <= W'(1));
endmodule

// File: rtl/asteroid_hit_ctrl.sv
// rtl/asteroid_hit_ctrl.sv - per-frame collision latching, asteroid lifecycle, hit/spawn pulses and score
module asteroid_hit_ctrl
    import asteroids_pkg::*;
#(
    parameter int RESPAWN_FRAMES = 120,
    parameter int GRACE_FRAMES   = 8,
    parameter int PTS_LARGE      = PTS_LARGE_DEF,
    parameter int PTS_MED        = PTS_MED_DEF,
    parameter int PTS_SMALL      = PTS_SMALL_DEF,
    parameter int SCORE_W        = 16
) (
    input logic          clk,
    input logic          resetN,
    asteroid_hit_ctrl_if.slave bus
);
    localparam int SUM_W = SCORE_W + 33;

    ctrl_state_t        state_q, state_d;
    ast_size_t          size_q, size_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               t_hit_q, t_hit_d, s_hit_q, s_hit_d;
    logic               new_q, new_d, hit_q, hit_d, kill_q, kill_d, ship_q, ship_d;

    logic               resp_load, resp_dec, resp_le_one;
    logic               grace_load, grace_dec, grace_zero;
    logic               pix_qual;
    logic [31:0]        pts;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_add;

    frame_counter #(.MAX_VAL(RESPAWN_FRAMES), .RST_FULL(1'b1)) u_respawn (
        .clk(clk), .resetN(resetN), .load_i(resp_load), .dec_i(resp_dec),
        .zero_o(), .le_one_o(resp_le_one)
    );

    frame_counter #(.MAX_VAL(GRACE_FRAMES), .RST_FULL(1'b0)) u_grace (
        .clk(clk), .resetN(resetN), .load_i(grace_load), .dec_i(grace_dec),
        .zero_o(grace_zero), .le_one_o()
    );

    always_comb begin
        case (size_q)
            AST_LARGE: pts = 32'(PTS_LARGE);
            AST_MED:   pts = 32'(PTS_MED);
            default:   pts = 32'(PTS_SMALL);
        endcase
        sum       = SUM_W'(score_q) + SUM_W'(pts);
        score_add = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= WAIT;
            size_q  <= AST_NONE;
            score_q <= '0;
            t_hit_q <= 1'b0;
            s_hit_q <= 1'b0;
            new_q   <= 1'b0;
            hit_q   <= 1'b0;
            kill_q  <= 1'b0;
            ship_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            score_q <= score_d;
            t_hit_q <= t_hit_d;
            s_hit_q <= s_hit_d;
            new_q   <= new_d;
            hit_q   <= hit_d;
            kill_q  <= kill_d;
            ship_q  <= ship_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        score_d    = score_q;
        new_d      = 1'b0;
        hit_d      = 1'b0;
        kill_d     = 1'b0;
        ship_d     = 1'b0;
        resp_load  = 1'b0;
        resp_dec   = 1'b0;
        grace_load = 1'b0;
        grace_dec  = 1'b0;

        // Latches are evaluated from their old value on vsync, then restart with any coincident pixel.
        pix_qual = (state_q == ALIVE) && grace_zero && bus.pixel_valid && bus.asteroid_px;
        t_hit_d  = (t_hit_q && !bus.vsync) || (pix_qual && bus.torpedo_px);
        s_hit_d  = (s_hit_q && !bus.vsync) || (pix_qual && bus.ship_px);

        case (state_q)
            WAIT: begin
                if (bus.vsync) begin
                    resp_dec = 1'b1;
                    if (resp_le_one) state_d = SPAWN;
                end
            end
            SPAWN: begin
                new_d      = 1'b1;
                size_d     = AST_LARGE;
                grace_load = 1'b1;
                state_d    = ALIVE;
            end
            ALIVE: begin
                if (bus.vsync) begin
                    if (!grace_zero) begin
                        grace_dec = 1'b1;
                    end else begin
                        if (t_hit_q) begin
                            hit_d      = 1'b1;
                            kill_d     = 1'b1;
                            score_d    = score_add;
                            grace_load = 1'b1;
                            case (size_q)
                                AST_LARGE: size_d = AST_MED;
                                AST_MED:   size_d = AST_SMALL;
                                default: begin
                                    size_d    = AST_NONE;
                                    resp_load = 1'b1;
                                    state_d   = WAIT;
                                end
                            endcase
                        end
                        ship_d = s_hit_q;
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    assign bus.new_asteroid = new_q;
    assign bus.asteroid_hit = hit_q;
    assign bus.torpedo_kill = kill_q;
    assign bus.ship_hit     = ship_q;
    assign bus.size_level   = size_q;
    assign bus.score        = score_q;
endmodule

// File: tb/tb_asteroid_hit_ctrl.sv
// tb/tb_asteroid_hit_ctrl.sv - randomized frame-level checks of asteroid_hit_ctrl against a game-rule model
module tb_asteroid_hit_ctrl;
    import asteroids_pkg::*;

    localparam int R = 3;
    localparam int G = 8;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    asteroid_hit_ctrl_if #(.SCORE_W(16)) bus16();
    asteroid_hit_ctrl_if #(.SCORE_W(7))  bus7();

    asteroid_hit_ctrl #(.RESPAWN_FRAMES(R), .GRACE_FRAMES(G), .SCORE_W(16)) dut16 (
        .clk(clk), .resetN(resetN), .bus(bus16)
    );
    asteroid_hit_ctrl #(.RESPAWN_FRAMES(R), .GRACE_FRAMES(G), .SCORE_W(7)) dut7 (
        .clk(clk), .resetN(resetN), .bus(bus7)
    );

    int checks = 0;
    int failures = 0;

    bit m_alive, m_pend_t, m_pend_s;
    int m_size, m_resp, m_grace, m_score, small_hits;

    // {p1, p2, p3, in-frame pulses, size16, size7, score16, score7}
    logic [58:0] f_obs, f_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit vs, input bit pv, input bit a, input bit t, input bit s);
        bus16.vsync = vs; bus16.pixel_valid = pv; bus16.asteroid_px = a;
        bus16.torpedo_px = t; bus16.ship_px = s;
        bus7.vsync = vs; bus7.pixel_valid = pv; bus7.asteroid_px = a;
        bus7.torpedo_px = t; bus7.ship_px = s;
    endtask

    function automatic logic [7:0] pulses();
        return {bus16.new_asteroid, bus16.asteroid_hit, bus16.torpedo_kill, bus16.ship_hit,
                bus7.new_asteroid, bus7.asteroid_hit, bus7.torpedo_kill, bus7.ship_hit};
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int pts(input int sz);
        return (sz == 0) ? 20 : (sz == 1) ? 50 : 100;
    endfunction

    task automatic model_reset();
        m_alive = 0; m_size = 3; m_resp = R; m_grace = 0; m_score = 0;
        m_pend_t = 0; m_pend_s = 0;
    endtask

    // One frame of random pixels followed by a vsync and three observation cycles.
    task automatic run_frame(input bit want_t, input bit want_s, input bit vs_pix);
        int n, ft, fs;
        bit pv, a, t, s, seen_t, seen_s, latchable, hit_t, hit_s;
        bit e_hit, e_ship, e_spawn, c_t, c_s;
        logic [3:0] e1, e2;
        logic [7:0] p1, p2, p3, q;
        n  = 12 + int'($urandom_range(0, 8));
        ft = int'($urandom_range(0, n - 1));
        fs = int'($urandom_range(0, n - 1));
        seen_t = 0; seen_s = 0; q = '0;
        latchable = m_alive && (m_grace == 0);
        for (int i = 0; i < n; i++) begin
            pv = ($urandom_range(0, 3) != 0);
            a  = 1'($urandom_range(0, 1));
            t  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            if (want_t && i == ft) begin pv = 1; a = 1; t = 1; end
            if (want_s && i == fs) begin pv = 1; a = 1; s = 1; end
            if (!want_t && pv && a) t = 0;
            if (!want_s && pv && a) s = 0;
            seen_t |= pv & a & t;
            seen_s |= pv & a & s;
            drive(1'b0, pv, a, t, s);
            tick();
            q |= pulses();
        end
        c_t = 0; c_s = 0;
        if (vs_pix) begin
            c_t = 1'($urandom_range(0, 1));
            c_s = 1'($urandom_range(0, 1));
            drive(1'b1, 1'b1, 1'b1, c_t, c_s);
        end else begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        hit_t = m_pend_t | (latchable & seen_t);
        hit_s = m_pend_s | (latchable & seen_s);
        e_hit = 0; e_ship = 0; e_spawn = 0;
        if (!m_alive) begin
            if (m_resp <= 1) begin
                e_spawn = 1; m_alive = 1; m_size = 0; m_grace = G;
            end else begin
                m_resp--;
            end
        end else if (m_grace > 0) begin
            m_grace--;
        end else begin
            if (hit_t) begin
                e_hit = 1;
                m_score += pts(m_size);
                m_grace = G;
                if (m_size == 2) small_hits++;
                m_size++;
                if (m_size == 3) begin m_alive = 0; m_resp = R; end
            end
            e_ship = hit_s;
        end
        m_pend_t = latchable & c_t;
        m_pend_s = latchable & c_s;
        tick();
        p1 = pulses();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        p2 = pulses();
        tick();
        p3 = pulses();
        e1 = {1'b0, e_hit, e_hit, e_ship};
        e2 = {e_spawn, 3'b000};
        f_obs = {p1, p2, p3, q, bus16.size_level, bus7.size_level, bus16.score, bus7.score};
        f_exp = {e1, e1, e2, e2, 8'h00, 8'h00, 2'(m_size), 2'(m_size),
                 16'(sat(m_score, 16)), 7'(sat(m_score, 7))};
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if ({pulses(), bus16.size_level, bus7.size_level, bus16.score, bus7.score}
            !== {8'h00, 2'd3, 2'd3, 16'd0, 7'd0}) begin
            failures++;
            $display("FAIL reset_state got %h required %h",
                     {pulses(), bus16.size_level, bus7.size_level, bus16.score, bus7.score},
                     {8'h00, 2'd3, 2'd3, 16'd0, 7'd0});
        end
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_spawn();
        for (int i = 0; i < R; i++) begin
            run_frame(1'b1, 1'b1, 1'b0);
            checks++;
            if (f_obs !== f_exp || f_obs[50] !== (i == R - 1)) begin
                failures++;
                $display("FAIL spawn frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
    endtask

    task automatic test_large_hit();
        for (int i = 0; i <= G; i++) begin
            run_frame(1'b1, 1'b0, 1'b0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL large_hit frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
        checks++;
        if (f_obs[57:56] !== 2'b11 || bus16.score !== 16'd20 || bus16.size_level !== AST_MED) begin
            failures++;
            $display("FAIL large_hit_result got pulses=%b score=%0d size=%0d required 11/20/1",
                     f_obs[57:56], bus16.score, bus16.size_level);
        end
    endtask

    task automatic test_med_hit();
        for (int i = 0; i <= G; i++) begin
            run_frame(1'b1, 1'b0, 1'b0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL med_hit frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
        checks++;
        if (bus16.score !== 16'd70 || bus16.size_level !== AST_SMALL) begin
            failures++;
            $display("FAIL med_hit_result got score=%0d size=%0d required 70/2",
                     bus16.score, bus16.size_level);
        end
    endtask

    task automatic test_small_hit();
        for (int i = 0; i <= G; i++) begin
            run_frame(i == G, 1'b0, 1'b0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL small_hit frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
        checks++;
        if (bus16.score !== 16'd170 || bus7.score !== 7'd127 || bus16.size_level !== AST_NONE) begin
            failures++;
            $display("FAIL small_hit_result got score16=%0d score7=%0d size=%0d required 170/127/3",
                     bus16.score, bus7.score, bus16.size_level);
        end
        for (int i = 0; i < R; i++) begin
            run_frame(1'b1, 1'b1, 1'b0);
            checks++;
            if (f_obs !== f_exp || f_obs[50] !== (i == R - 1)) begin
                failures++;
                $display("FAIL respawn frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
    endtask

    task automatic test_ship_and_torpedo();
        for (int i = 0; i < G + 2; i++) begin
            run_frame(i == G + 1, i == G + 1, 1'b0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL ship_torp frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
        checks++;
        if (f_obs[57:55] !== 3'b111 || bus16.score !== 16'd190) begin
            failures++;
            $display("FAIL ship_torp_result got pulses=%b score=%0d required 111/190",
                     f_obs[57:55], bus16.score);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 400 && small_hits < 5; i++) begin
            run_frame(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL saturation frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
        checks++;
        if (bus7.score !== 7'h7f || small_hits < 5) begin
            failures++;
            $display("FAIL saturation_result got score7=%0d small_hits=%0d required 127/5",
                     bus7.score, small_hits);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_frame($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) == 0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL random frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q;
        for (int i = 0; i < 60 && !(m_alive && m_grace == 0); i++) begin
            run_frame(1'b0, 1'b0, 1'b0);
            checks++;
            if (f_obs !== f_exp) begin
                failures++;
                $display("FAIL reset_mid_pre frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        resetN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        resetN = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        q = pulses();
        for (int i = 0; i < 3; i++) begin
            tick();
            q |= pulses();
        end
        checks++;
        if ({q, bus16.size_level, bus16.score} !== {8'h00, 2'd3, 16'd0}) begin
            failures++;
            $display("FAIL reset_mid_state got %h required %h",
                     {q, bus16.size_level, bus16.score}, {8'h00, 2'd3, 16'd0});
        end
        model_reset();
        for (int i = 0; i < R; i++) begin
            run_frame(1'b0, 1'b0, 1'b0);
            checks++;
            if (f_obs !== f_exp || f_obs[50] !== (i == R - 1)) begin
                failures++;
                $display("FAIL reset_mid_respawn frame %0d got %h required %h", i, f_obs, f_exp);
            end
        end
    endtask

    initial begin
        small_hits = 0;
        model_reset();
        test_reset();
        test_spawn();
        test_large_hit();
        test_med_hit();
        test_small_hit();
        test_ship_and_torpedo();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/asteroid_hit_ctrl.md
Name: asteroid_hit_ctrl

Overview:
- Drives the `new_asteroid` and `asteroid_hit` inputs of the asteroid unit; it is the other end of that control interface.
- Watches per-pixel draw masks from the VGA chain (asteroid, torpedo, ship) during active video and records collisions per frame.
- On the next vsync pulse it issues hit/spawn pulses, tracks asteroid size level and lifetime, and keeps a score.
- Sits in the game top between the sprite units and the score display.

Parameters:
- RESPAWN_FRAMES, 120: vsyncs to wait after the small asteroid is destroyed (or after reset) before `new_asteroid`.
- GRACE_FRAMES, 8: vsyncs after any hit/spawn during which collisions are ignored.
- PTS_LARGE, 20: score added for a hit on a large asteroid.
- PTS_MED, 50: score added for a hit on a medium asteroid.
- PTS_SMALL, 100: score added for a hit on a small asteroid.
- SCORE_W, 16: score counter width.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-low reset
- vsync  in  1  one-cycle frame pulse (blanking period)
- pixel_valid  in  1  current cycle is an active-video pixel
- asteroid_px  in  1  asteroid sprite draws an opaque pixel here
- torpedo_px  in  1  torpedo draws a pixel here
- ship_px  in  1  ship draws a pixel here
- new_asteroid  out  1  one-cycle pulse: spawn large asteroid
- asteroid_hit  out  1  one-cycle pulse: shrink asteroid one level
- torpedo_kill  out  1  one-cycle pulse: retire the torpedo
- ship_hit  out  1  one-cycle pulse: ship collided with asteroid
- size_level  out  2  0=large, 1=med, 2=small, 3=none alive
- score  out  SCORE_W  accumulated points, saturating

Behaviour:
- Reset (resetN=0 at posedge):
  - All pulse outputs 0, score=0, size_level=3.
  - State WAIT with frame_cnt=RESPAWN_FRAMES.
  - Collision latches and grace counter cleared.
  - Reset overrides everything, including a vsync in the same cycle.
- Collision latches, set in the cycle after a qualifying pixel and held until the vsync evaluation:
  - t_hit is set on pixel_valid & asteroid_px & torpedo_px.
  - s_hit is set on pixel_valid & asteroid_px & ship_px.
  - Latches only set in state ALIVE with grace_cnt==0.
  - A pixel coincident with vsync is still latched and is evaluated at the next vsync.
- Latches are cleared on every vsync after evaluation. Evaluation reads the pre-clear value.
- States:
  - WAIT: on each vsync, frame_cnt decrements. On a vsync with frame_cnt==1 (or 0), go to SPAWN.
  - SPAWN: pulse new_asteroid exactly one cycle; size_level:=0; grace_cnt:=GRACE_FRAMES; go to ALIVE.
  - ALIVE, on vsync:
    - If grace_cnt>0, decrement it and ignore the latches.
    - Else if t_hit: pulse asteroid_hit and torpedo_kill, add PTS for current size_level, grace_cnt:=GRACE_FRAMES.
      - size_level 0→1 and 1→2, staying in ALIVE.
      - From size_level 2: size_level:=3, frame_cnt:=RESPAWN_FRAMES, go to WAIT.
    - Independently, s_hit pulses ship_hit (even when t_hit is also set); no score change.
- Pulse timing: all output pulses assert in the cycle after the vsync cycle and last exactly 1 cycle. new_asteroid asserts the cycle after the SPAWN entry.
- new_asteroid and asteroid_hit are never asserted in the same cycle.
- Score arithmetic: unsigned add of zero-extended PTS; saturates at all-ones with no wrap.
- Counter widths: frame_cnt and grace_cnt use $clog2(max+1).
- RESPAWN_FRAMES=0 behaves as 1 (spawn at first vsync).
- Inputs outside pixel_valid are ignored.

Decomposition:
- Shared package asteroids_pkg:
  - typedef enum ast_size_t {AST_LARGE, AST_MED, AST_SMALL, AST_NONE} (2 bits), reused by the asteroid unit for ast_type.
  - typedef enum ctrl_state_t {WAIT, SPAWN, ALIVE}.
  - Point constants.
- One natural sub-module, frame_counter: loadable down-counter that decrements on vsync and flags zero. Instantiated twice, for respawn and grace.

Test Plan:
- Reset release, RESPAWN_FRAMES=3: new_asteroid pulses once, one cycle after the SPAWN state following the 3rd vsync; size_level 3→0; score=0.
- ALIVE with grace expired: one overlapping pixel in frame N → at vsync N, asteroid_hit=1 and torpedo_kill=1 for 1 cycle; score 0→20; size_level=1.
- Hit again during grace: overlapping pixels in each of the next 8 frames → no pulses, score stays 20; overlap in the 9th frame → hit, score=70, size_level=2.
- Small hit: overlap at size_level=2 → asteroid_hit, score +100, size_level=3; new_asteroid after exactly RESPAWN_FRAMES further vsyncs; no asteroid_hit is ever concurrent with it.
- Ship and torpedo overlap in the same frame → ship_hit, asteroid_hit and torpedo_kill all pulse the same cycle; overlap with pixel_valid=0 → no latch.
- Score saturation with SCORE_W=7: five small-asteroid-level hits → score saturates at 127, no wrap.
- resetN low mid-ALIVE with latched hits, released coincident with vsync → no pulses; state WAIT; score=0.
